// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_SAMPLE = 8;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick enable: one-cycle pulse every TICK_CEIL+1 clocks, with sync clear.
module uart_baud_tick #(
  parameter int TICK_CEIL = 650
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_CEIL > 0) ? $clog2(TICK_CEIL + 1) : 1;
  localparam logic [CW-1:0] CEIL = CW'(TICK_CEIL);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || cnt == CEIL) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CEIL);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; optional even parity via UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICK_CEIL = 650
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [3:0] SUB_MID  = 4'(UART_MID_SAMPLE - 1);
  localparam logic [3:0] SUB_BIT  = 4'(UART_OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic        rx_meta, rxs, rxs_d;
  uart_state_t state;
  logic [3:0]  sub;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        armed;
  logic        tick;
  logic        clr;
  logic        par_fail;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // Start edge realigns the tick phase so every sample lands mid-bit.
  assign clr = (state == ST_IDLE) && armed && rxs_d && !rxs;

  uart_baud_tick #(.TICK_CEIL(TICK_CEIL)) u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (clr),
    .tick   (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      par_bad <= 1'b0;
    end else if (state == ST_PARITY && tick && sub == SUB_BIT) begin
      par_bad <= rxs ^ (^shreg);
    end
  end

  assign par_fail = par_bad;
`else
  assign par_fail = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sub        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      armed      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rxs) armed <= 1'b1;
          if (clr) begin
            state <= ST_START;
            sub   <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sub == SUB_MID) begin
              sub     <= '0;
              bit_idx <= '0;
              state   <= rxs ? ST_IDLE : ST_DATA;
            end else begin
              sub <= sub + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (sub == SUB_BIT) begin
              sub   <= '0;
              shreg <= {rxs, shreg[7:1]};
              if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              sub <= sub + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (sub == SUB_BIT) begin
              sub   <= '0;
              state <= ST_STOP;
            end else begin
              sub <= sub + 4'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (sub == SUB_BIT) begin
              sub        <= '0;
              state      <= ST_IDLE;
              parity_err <= par_fail;
              if (!rxs) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end else if (!par_fail) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end
            end else begin
              sub <= sub + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial link: recovers 8-bit frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous `rx` line using 16x oversampling. It runs in the system clock domain and generates its own oversampling tick enable rather than a derived clock. It sits opposite the transmit path and hands each received byte to downstream logic as a one-cycle valid pulse.

## Interface
- `TICK_CEIL`, 650: tick counter terminal value. One oversample tick every `TICK_CEIL+1` clocks. The default gives 9600 baud x16 at 100 MHz.
- `clk_in`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk_in`.
- `data_out`  out  8  last good byte; held until the next good frame.
- `data_valid`  out  1  one-cycle pulse; `data_out` is valid on the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch (see Configuration).
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer. Edge detection and sampling use only the synchronized value `rxs`.
- **Tick counter**
  - Counts 0..`TICK_CEIL`; `tick` is asserted when the count equals `TICK_CEIL`, then the count wraps to 0.
  - The counter is cleared when a start edge is detected, so frame timing aligns to the edge.
  - A 4-bit sub-counter counts ticks within the current state.
- **FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE**
  - IDLE: leaves on a high-to-low transition of `rxs`, but only if `armed`=1. It clears the tick counter and sub-counter.
  - START: after 8 ticks (mid start bit), samples `rxs`. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no pulses.
  - DATA: every 16 ticks, samples `rxs` into the shift register MSB and shifts right. After the 8th sample, goes to PARITY if enabled, otherwise STOP.
  - STOP: after 16 ticks (mid stop bit), samples `rxs` and returns to IDLE on the same cycle.
- **Frame outcome at the stop sample**
  - Stop=1 and no parity error: `data_out` is loaded and `data_valid` pulses.
  - Stop=0: `frame_err` pulses, `data_out` is unchanged, and `armed` is cleared.
  - `armed` is set again once `rxs`=1 in IDLE. This blocks false starts during a line break.
- Returning to IDLE at mid stop bit leaves half a bit of margin, so back-to-back frames are received with no loss.

## Timing
- Reset values:
  - `data_out`=8'h00.
  - `data_valid`, `frame_err`, `parity_err`, `busy` = 0.
  - FSM in IDLE, `armed`=1, all counters 0.
- Reset asserted mid-frame aborts the frame immediately; no pulse is produced.
- Edge-detect cycle E: 2-3 clocks after the `rx` fall, because of the synchronizer.
- Let T = `TICK_CEIL`+1. Sample n (n=0 is the start bit) is taken at E + (8+16n)·T.
- Outputs register one clock after the stop sample. `data_valid` rises at E + (8+16·9)·T + 1, or E + (8+16·10)·T + 1 with parity.
- `busy` rises on cycle E+1 and falls together with the outcome pulse.
- `frame_err` and `parity_err` may pulse on the same cycle. `data_valid` is never asserted together with either error.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - The PARITY state is inserted after DATA and samples one even-parity bit 16 ticks after the last data sample.
  - A mismatch makes `parity_err` pulse at the stop sample and suppresses `data_valid`.
- Undefined:
  - There is no PARITY state; the frame is 10 bits.
  - `parity_err` is tied to 0. The port stays so the interface does not change.

## Structure
- Package `uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS`=8, `UART_OVERSAMPLE`=16 and `UART_MID_SAMPLE`=8.
- Sub-module `uart_baud_tick`: parameter `TICK_CEIL`; inputs `clk_in`, `rst` and sync clear `clr`; output one-cycle `tick`.

## Test plan
All tests use `TICK_CEIL`=3, so one bit lasts 64 clocks.
- Send 8'hA5 at the nominal rate -> `data_valid` pulses once with `data_out`=8'hA5, and `frame_err`=0.
- Send 8'h00 then 8'hFF back-to-back with no idle gap -> two `data_valid` pulses, with `data_out` equal to 00 then FF.
- Drive a 20-clock low glitch on `rx` -> no output pulses, `busy` returns to 0 after 32 clocks, and the next frame 8'h3C is received correctly.
- Hold `rx` low for 15 bit-times (a break) -> exactly one `frame_err`; no new frame starts until `rx` returns high; then 8'h81 is received.
- Assert `rst` during the 4th data bit of 8'h5A, then send 8'h12 -> no pulse for 8'h5A; 8'h12 is received; all outputs match the reset values while reset is asserted.
- With `UART_RX_PARITY_EN` defined, send 8'h07 with parity bit 0 (wrong) -> `parity_err` pulses, there is no `data_valid`, and `data_out` is unchanged.
